// File: rtl/irq_pkg.sv
// Shared types and sizing for the pending-request arbiter and its encoder.
package irq_pkg;

    localparam int IRQ_N     = 8;
    localparam int IRQ_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } irq_arb_state_t;

endpackage

// File: rtl/irq_pending_arbiter_if.sv
// Valid/ready grant channel from the arbiter to the interrupt/service logic.
interface irq_pending_arbiter_if
    import irq_pkg::*;
#(
    parameter int IDX_W = IRQ_IDX_W
);

    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_ready;

    modport master (
        output out_valid,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        output out_ready
    );

endinterface

// File: rtl/irq_pri_enc.sv
// Combinational highest-index-wins priority encoder with an any-set flag.
module irq_pri_enc
    import irq_pkg::*;
#(
    parameter int N     = IRQ_N,
    parameter int IDX_W = IRQ_IDX_W
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/irq_pending_arbiter.sv
// Latches request lines into a pending register and delivers one index at a time.
// Define EDGE_EN for rising-edge requests with a sticky overflow flag.
module irq_pending_arbiter
    import irq_pkg::*;
#(
    parameter int N     = IRQ_N,
    parameter int IDX_W = IRQ_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    irq_pending_arbiter_if.master out_if,
    output logic [N-1:0]          pending,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    generate
        if (IDX_W != $clog2(N)) begin : g_bad_width
            $error("irq_pending_arbiter: IDX_W must equal $clog2(N)");
        end
    endgenerate

    irq_arb_state_t   r_state;
    irq_arb_state_t   w_state_next;
    logic             r_out_valid;
    logic             w_valid_next;
    logic [IDX_W-1:0] r_out_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [N-1:0]     r_pending;
    logic [N-1:0]     w_set;
    logic [N-1:0]     w_clr;
    logic             w_accept;
    logic [IDX_W-1:0] w_enc_idx;
    logic             w_enc_any;

    irq_pri_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pri_enc (
        .i_vec (r_pending),
        .o_idx (w_enc_idx),
        .o_any (w_enc_any)
    );

`ifdef EDGE_EN
    logic [N-1:0] r_req_d;
    logic         r_overflow;
    logic         w_ovf_event;

    // req_d resets low so a request held through reset release counts as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_d <= '0;
        end else begin
            r_req_d <= req;
        end
    end

    assign w_set       = req & ~r_req_d;
    assign w_ovf_event = |(w_set & r_pending & ~w_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_event) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;
`else
    logic w_unused_ovf_clr;

    assign w_set            = req;
    assign overflow         = 1'b0;
    assign w_unused_ovf_clr = ovf_clr;
`endif

    assign w_accept = r_out_valid && out_if.out_ready;

    always_comb begin
        w_clr = '0;
        if (w_accept) begin
            w_clr[r_out_idx] = 1'b1;
        end
    end

    // Set is OR-ed in after the clear so a re-request during acceptance survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_out_valid;
        w_idx_next   = r_out_idx;
        case (r_state)
            IDLE: begin
                w_valid_next = 1'b0;
                if (w_enc_any) begin
                    w_idx_next   = w_enc_idx;
                    w_valid_next = 1'b1;
                    w_state_next = OFFER;
                end
            end
            OFFER: begin
                w_valid_next = 1'b1;
                if (out_if.out_ready) begin
                    w_valid_next = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_valid_next = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= w_valid_next;
            r_out_idx   <= w_idx_next;
        end
    end

    assign out_if.out_valid = r_out_valid;
    assign out_if.out_idx   = r_out_idx;
    assign pending          = r_pending;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Randomized and directed bench for irq_pending_arbiter against a cycle-level reference model.
module tb_irq_pending_arbiter;
    import irq_pkg::*;

    localparam int N     = IRQ_N;
    localparam int IDX_W = IRQ_IDX_W;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] pending;
    logic         overflow;
    logic         ovfClr;

    irq_pending_arbiter_if #(.IDX_W(IDX_W)) outIf ();

    irq_pending_arbiter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .out_if   (outIf.master),
        .pending  (pending),
        .overflow (overflow),
        .ovf_clr  (ovfClr)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    bit [N-1:0] mPend;
    bit [N-1:0] mReqD;
    bit         mValid;
    bit         mOvf;
    int         mIdx;

    function automatic int highestSet(input bit [N-1:0] v);
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mPend  = '0;
        mReqD  = '0;
        mValid = 1'b0;
        mOvf   = 1'b0;
        mIdx   = 0;
    endtask

    // One clock of the spec's rules, using the state as it was before the edge.
    task automatic modelStep(input bit [N-1:0] r, input bit rdy, input bit oc);
        bit [N-1:0] setVec;
        bit [N-1:0] clrVec;
        bit         accepted;
        accepted = mValid && rdy;
`ifdef EDGE_EN
        setVec = r & ~mReqD;
`else
        setVec = r;
`endif
        clrVec = accepted ? (N'(1) << mIdx) : '0;
`ifdef EDGE_EN
        if ((setVec & mPend & ~clrVec) != 0) mOvf = 1'b1;
        else if (oc) mOvf = 1'b0;
`else
        mOvf = 1'b0 & oc;
`endif
        if (!mValid) begin
            if (mPend != 0) begin
                mIdx   = highestSet(mPend);
                mValid = 1'b1;
            end
        end else if (rdy) begin
            mValid = 1'b0;
        end
        mPend = (mPend & ~clrVec) | setVec;
        mReqD = r;
    endtask

    task automatic compareModel();
        checkOutput("out_valid", 32'(outIf.out_valid), 32'(mValid));
        checkOutput("out_idx", 32'(outIf.out_idx), 32'(mIdx));
        checkOutput("pending", 32'(pending), 32'(mPend));
        checkOutput("overflow", 32'(overflow), 32'(mOvf));
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic rdy, input logic oc);
        @(negedge clk);
        req             = r;
        outIf.out_ready = rdy;
        ovfClr          = oc;
        @(posedge clk);
        modelStep(r, rdy, oc);
        #1;
        compareModel();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst             = 1'b1;
        req             = '0;
        ovfClr          = 1'b0;
        outIf.out_ready = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        checkOutput("reset_valid", 32'(outIf.out_valid), 32'd0);
        checkOutput("reset_pending", 32'(pending), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(8'h00, 1'b0, 1'b0);

        // Single request: two cycles to valid, cleared on handshake.
        applyStimulus(8'h10, 1'b1, 1'b0);
        checkOutput("single_valid_early", 32'(outIf.out_valid), 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("single_valid", 32'(outIf.out_valid), 32'd1);
        checkOutput("single_idx", 32'(outIf.out_idx), 32'd4);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("single_pending_clr", 32'(pending), 32'd0);

        // Two simultaneous requests, highest index first.
        applyStimulus(8'h81, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("pair_first_idx", 32'(outIf.out_idx), 32'd7);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("pair_gap_valid", 32'(outIf.out_valid), 32'd0);
        checkOutput("pair_gap_pending", 32'(pending), 32'h01);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("pair_second_valid", 32'(outIf.out_valid), 32'd1);
        checkOutput("pair_second_idx", 32'(outIf.out_idx), 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("pair_idle", 32'(outIf.out_valid), 32'd0);

        // Offer held stable while a higher-priority request arrives.
        applyStimulus(8'h04, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h40, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("hold_idx", 32'(outIf.out_idx), 32'd2);
        checkOutput("hold_pending", 32'(pending), 32'h44);
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("hold_next_idx", 32'(outIf.out_idx), 32'd6);
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);

        // Re-request while pending.
        applyStimulus(8'h08, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h08, 1'b0, 1'b0);
`ifdef EDGE_EN
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);
        checkOutput("ovf_pending3", 32'(pending[3]), 32'd1);
`else
        checkOutput("ovf_tied_low", 32'(overflow), 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b1);
`endif
        for (int i = 0; i < 4; i++) applyStimulus(8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(N'($urandom & $urandom), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0));
        end

        for (int i = 0; i < 20; i++) applyStimulus(8'h00, 1'b1, 1'b0);

        // Reset in the middle of an offer.
        applyStimulus(8'h0C, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("rst_pre_valid", 32'(outIf.out_valid), 32'd1);
        checkOutput("rst_pre_pending", 32'(pending), 32'h0C);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", 32'(outIf.out_valid), 32'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_post_pending", 32'(pending), 32'd0);
        checkOutput("rst_post_idx", 32'(outIf.out_idx), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/irq_pending_arbiter.md
# irq_pending_arbiter

- Collects eight asynchronous-origin request lines into a pending register.
- Picks the highest-index pending request (bit 7 highest priority) and presents its 3-bit index to the downstream consumer over a valid/ready handshake.
- Clears that pending bit when the consumer accepts it.
- Sits directly upstream of the interrupt/service logic and replaces the stateless encode of a raw request vector with latched, acknowledged, one-at-a-time delivery.

## Interface
Parameters:
- N, 8, number of request lines.
- IDX_W, 3, index width; must equal $clog2(N).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset; one clock, asynchronous, active-high.
- req  input  N  request lines, sampled on clk; synchronised upstream.
- out_valid  output  1  out_idx holds a granted request.
- out_idx  output  IDX_W  index of the granted request.
- out_ready  input  1  consumer accepts out_idx this cycle.
- pending  output  N  current pending register, for status readback.
- overflow  output  1  sticky: a request re-arrived while its bit was still pending.
- ovf_clr  input  1  synchronous clear of overflow.

## Operation
- Set vector:
  - With EDGE_EN, set = req & ~req_d.
  - Without EDGE_EN, set = req.
- Clear vector: clr = one-hot(out_idx) when out_valid && out_ready, else 0.
- Pending update: pending <= (pending & ~clr) | set. Set wins over clear on the same bit, so a re-request during acceptance is retained.
- FSM, two states:
  - IDLE:
    - out_valid = 0.
    - If pending != 0, register out_idx = highest set index of pending, assert out_valid, go to OFFER.
    - Else stay in IDLE.
  - OFFER:
    - out_valid = 1; out_idx held stable, even if a higher-priority request arrives.
    - On out_ready, clear the bit and go to IDLE.
    - Without out_ready, remain in OFFER indefinitely.
- Width: out_idx is zero-extended/truncated to IDX_W; unused encodings never produced when N = 2^IDX_W.
- Overflow:
  - Set when set[i] && pending[i] && !clr[i] for any i.
  - ovf_clr clears it; a simultaneous set event wins over ovf_clr.
- Reset mid-OFFER aborts the offer: out_valid drops asynchronously and all pending requests are discarded.

## Timing
- Reset values: pending = 0, out_valid = 0, out_idx = 0, overflow = 0, FSM = IDLE, req_d = 0.
- With EDGE_EN and req high at reset release, the first sampled cycle counts as a rising edge.
- Latency, req sampled high at edge k to out_valid: pending set after edge k, out_valid high after edge k+1 (2 cycles).
- Throughput: one grant per 2 cycles minimum. out_valid is low for exactly one cycle after each handshake, even if pending is nonzero.
- out_valid, out_idx and pending are registered outputs. out_ready has no combinational path to any output.

## Configuration
- EDGE_EN defined:
  - Adds the req_d register.
  - Requests are rising-edge triggered: one pending set per 0→1 transition.
  - overflow is active.
- EDGE_EN undefined:
  - Level triggered: a held request re-pends every cycle, including the cycle after its acceptance.
  - req_d is absent.
  - overflow is tied 0 and ovf_clr is ignored.

## Structure
- Shared package irq_pkg:
  - localparams IRQ_N = 8 and IRQ_IDX_W = 3.
  - FSM state typedef irq_arb_state_t {IDLE, OFFER}.
- One sub-module: irq_pri_enc, a purely combinational N-to-IDX_W highest-index-wins encoder with an any-set flag, instantiated on pending.

## Test plan
- After reset, req = 8'h00 for 5 cycles -> out_valid = 0, pending = 8'h00, overflow = 0 throughout.
- Single pulse req = 8'h10 with out_ready = 1 -> out_valid high 2 cycles later with out_idx = 4; pending = 8'h00 on the cycle after the handshake.
- req = 8'h81 pulsed together, out_ready = 1 -> grants out_idx = 7, then out_idx = 0 two cycles later, then idle.
- Hold out_ready = 0 with out_idx = 2 offered, then pulse req = 8'h40 -> out_idx stays 2 until accepted; next grant is 6.
- EDGE_EN: pulse req[3] twice while pending[3] = 1 and out_ready = 0 -> overflow = 1; assert ovf_clr -> overflow = 0 next cycle, pending[3] still 1.
- Assert rst while out_valid = 1 with pending = 8'h0C -> out_valid = 0 immediately; pending = 0 and out_idx = 0 after release.
